// File: rtl/axis_pkt_checker_pkg.sv
// Shared widths, throttle modulus, tuser length field bounds and FSM encoding for the AXIS packet checker.
// Also holds the per-packet completion record and a saturating error-count increment.
package axis_pkt_checker_pkg;

  localparam int PKT_CNT_W  = 32;
  localparam int BYTE_CNT_W = 64;
  localparam int ERR_CNT_W  = 16;
  localparam int THR_MOD    = 100;
  localparam int THR_W      = 7;
  localparam int LEN_LSB    = 0;
  localparam int LEN_MSB    = 15;
  localparam int LEN_W      = LEN_MSB - LEN_LSB + 1;
  localparam int ACC_W      = 17;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  typedef struct packed {
    logic             vld;
    logic [ACC_W-1:0] bytes;
    logic             len_err;
    logic             keep_err;
  } pkt_done_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v,
                                                   input logic                 en);
    return (en && (v != '1)) ? v + ERR_CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/axis_keep_decode.sv
// Combinational tkeep decode: byte popcount, all-ones flag and 2^k-1 (k>=1) contiguity flag.
// Zero latency; no flow control.
module axis_keep_decode #(
  parameter int KEEP_W = 64,
  parameter int CNT_W  = $clog2(KEEP_W + 1)
) (
  input  logic [KEEP_W-1:0] i_keep,
  output logic [CNT_W-1:0]  o_popcnt,
  output logic              o_contig,
  output logic              o_all_ones
);

  logic [CNT_W-1:0] w_cnt;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      w_cnt = w_cnt + CNT_W'(i_keep[i]);
    end
  end

  // keep+1 clears the low run of ones; anything left means a hole or a high byte.
  assign o_popcnt   = w_cnt;
  assign o_contig   = (i_keep != '0) && ((i_keep & (i_keep + KEEP_W'(1))) == '0);
  assign o_all_ones = &i_keep;

endmodule

// File: rtl/axis_pkt_checker.sv
// AXI-Stream sink that checks packet length (tuser[15:0]) and tkeep shape; stats land one cycle after tlast.
// tready is registered and throttled to a fixed duty cycle, and drops while enable is low.
module axis_pkt_checker
  import axis_pkt_checker_pkg::*;
#(
  parameter int C_DATA_WIDTH     = 512,
  parameter int C_USER_WIDTH     = 128,
  parameter int THROTTLE_PERCENT = 50
) (
  input  logic                      axis_aclk,
  input  logic                      axis_reset,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_USER_WIDTH-1:0]   s_axis_tuser,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  input  logic                      enable,
  input  logic                      clear,
  output logic [31:0]               pkt_count,
  output logic [63:0]               byte_count,
  output logic [15:0]               len_err_count,
  output logic [15:0]               keep_err_count,
  output logic                      err_flag,
  output logic                      busy
);

  localparam int KEEP_W = C_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(KEEP_W + 1);
  localparam logic [THR_W-1:0] THR_LIM  = THR_W'(THROTTLE_PERCENT);
  localparam logic [THR_W-1:0] THR_LAST = THR_W'(THR_MOD - 1);

  logic [THR_W-1:0]      r_thr;
  logic                  r_tready;
  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_busy;
  logic [LEN_W-1:0]      r_exp_len;
  logic [ACC_W-1:0]      r_acc;
  logic                  r_keep_err;
  pkt_done_t             r_done;
  logic [PKT_CNT_W-1:0]  r_pkt_cnt;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [ERR_CNT_W-1:0]  r_len_err_cnt;
  logic [ERR_CNT_W-1:0]  r_keep_err_cnt;
  logic                  r_err_flag;

  logic                  w_accept;
  logic                  w_first;
  logic [LEN_W-1:0]      w_len;
  logic [ACC_W-1:0]      w_acc_sum;
  logic                  w_kerr;
  logic [CNT_W-1:0]      w_popcnt;
  logic                  w_contig;
  logic                  w_all_ones;
  logic                  w_unused;

  // Payload bytes are never inspected; only tkeep and the length field matter.
  assign w_unused = ^{s_axis_tdata, s_axis_tuser};

  axis_keep_decode #(
    .KEEP_W (KEEP_W),
    .CNT_W  (CNT_W)
  ) u_keep_decode (
    .i_keep     (s_axis_tkeep),
    .o_popcnt   (w_popcnt),
    .o_contig   (w_contig),
    .o_all_ones (w_all_ones)
  );

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      r_thr    <= '0;
      r_tready <= 1'b0;
    end else begin
      r_thr    <= (r_thr == THR_LAST) ? '0 : r_thr + THR_W'(1);
      r_tready <= enable && (r_thr >= THR_LIM);
    end
  end

  assign w_accept = s_axis_tvalid && r_tready;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !s_axis_tlast) w_state_nxt = ST_IN_PKT;
      end
      ST_IN_PKT: begin
        w_busy = 1'b1;
        if (w_accept && s_axis_tlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Beat seen in IDLE is the first of its packet, so stale accumulators are bypassed.
  assign w_first   = (r_state == ST_IDLE);
  assign w_len     = w_first ? s_axis_tuser[LEN_MSB:LEN_LSB] : r_exp_len;
  assign w_acc_sum = (w_first ? '0 : r_acc) + ACC_W'(w_popcnt);
  assign w_kerr    = (!w_first && r_keep_err) || (s_axis_tlast ? !w_contig : !w_all_ones);

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      r_exp_len  <= '0;
      r_acc      <= '0;
      r_keep_err <= 1'b0;
      r_done     <= '0;
    end else begin
      r_done <= '0;
      if (w_accept) begin
        if (s_axis_tlast) begin
          r_exp_len       <= '0;
          r_acc           <= '0;
          r_keep_err      <= 1'b0;
          r_done.vld      <= !clear;
          r_done.bytes    <= w_acc_sum;
          r_done.len_err  <= (w_acc_sum != ACC_W'(w_len));
          r_done.keep_err <= w_kerr;
        end else begin
          r_exp_len  <= w_len;
          r_acc      <= w_acc_sum;
          r_keep_err <= w_kerr;
        end
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset || clear) begin
      r_pkt_cnt      <= '0;
      r_byte_cnt     <= '0;
      r_len_err_cnt  <= '0;
      r_keep_err_cnt <= '0;
      r_err_flag     <= 1'b0;
    end else if (r_done.vld) begin
      r_pkt_cnt      <= r_pkt_cnt + PKT_CNT_W'(1);
      r_byte_cnt     <= r_byte_cnt + BYTE_CNT_W'(r_done.bytes);
      r_len_err_cnt  <= sat_inc(r_len_err_cnt, r_done.len_err);
      r_keep_err_cnt <= sat_inc(r_keep_err_cnt, r_done.keep_err);
      if (r_done.len_err || r_done.keep_err) r_err_flag <= 1'b1;
    end
  end

  assign s_axis_tready  = r_tready;
  assign pkt_count      = r_pkt_cnt;
  assign byte_count     = r_byte_cnt;
  assign len_err_count  = r_len_err_cnt;
  assign keep_err_count = r_keep_err_cnt;
  assign err_flag       = r_err_flag;
  assign busy           = w_busy;

endmodule

// File: doc/axis_pkt_checker.md
AXIS_PKT_CHECKER -- requirements
Module: axis_pkt_checker

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 512, meaning the width of s_axis_tdata in bits.
REQ-002 SHALL have parameter C_USER_WIDTH, default 128, meaning the width of s_axis_tuser; bits [15:0] carry the packet length in bytes.
REQ-003 SHALL have parameter THROTTLE_PERCENT, default 50, legal range 0..99, meaning the percentage of cycles in which tready is withheld.
REQ-004 SHALL have port axis_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port axis_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have ports s_axis_tdata (input, C_DATA_WIDTH) and s_axis_tkeep (input, C_DATA_WIDTH/8), carrying beat data and byte enables.
REQ-007 SHALL have ports s_axis_tuser (input, C_USER_WIDTH), s_axis_tvalid (input, 1), s_axis_tlast (input, 1) and s_axis_tready (output, 1), forming the AXI-Stream sink.
REQ-008 SHALL have port enable, input, 1 bit: the sink accepts beats only while enable is high.
REQ-009 SHALL have port clear, input, 1 bit: a one-cycle pulse that zeroes the statistics and err_flag.
REQ-010 SHALL have outputs pkt_count [31:0], byte_count [63:0], len_err_count [15:0] and keep_err_count [15:0], holding the statistics.
REQ-011 SHALL have outputs err_flag (1 bit, sticky error indicator) and busy (1 bit, high while a packet is in progress).

Function
REQ-012 SHALL accept a beat in any cycle where s_axis_tvalid and s_axis_tready are both high.
REQ-013 SHALL keep a free-running throttle counter 0..99 that wraps to 0 after 99; s_axis_tready is registered and equals enable AND (throttle counter >= THROTTLE_PERCENT).
REQ-014 SHALL implement a state machine with two states. IDLE goes to IN_PKT on accepting a non-last beat. IN_PKT goes back to IDLE on accepting a beat with tlast. A single-beat packet leaves the state in IDLE.
REQ-015 SHALL capture tuser[15:0] as the expected length on the first beat of a packet only; tuser on later beats is ignored.
REQ-016 SHALL accumulate the popcount of tkeep per packet in a 17-bit accumulator, so the total never wraps.
REQ-017 SHALL flag a keep error when a non-last beat has tkeep not all-ones, or when a last beat has tkeep not of the form 2^k-1 with k>=1 (including all-zero); at most one keep error is counted per packet.
REQ-018 SHALL, one cycle after the tlast beat is accepted, do all of the following:
- increment pkt_count;
- add the packet byte total to byte_count;
- increment len_err_count if the total differs from the expected length;
- increment keep_err_count if the packet had a keep error.
REQ-019 SHALL let pkt_count and byte_count wrap modulo 2^32 and 2^64; len_err_count and keep_err_count saturate at 0xFFFF.
REQ-020 SHALL set err_flag in the same cycle as any error-count update, and hold it until clear or reset.
REQ-021 SHALL, when clear is high, zero all four counters and err_flag on the next edge. Clear beats a simultaneous packet completion: that packet is not counted. Packet-in-progress state is unaffected by clear.
REQ-022 SHALL hold all packet state while enable is low mid-packet; no beats are accepted, and the packet resumes when enable returns high.
REQ-023 SHALL drive busy high exactly when the state is IN_PKT.

Reset
REQ-024 SHALL, while axis_reset is high, set:
- the state to IDLE;
- all counters, err_flag, busy and s_axis_tready to 0;
- the throttle counter to 0;
- the per-packet accumulators to 0.
REQ-025 SHALL abandon a packet that is in progress when reset is asserted, without counting it; beats after reset are treated as the start of a new packet.

Structure
REQ-026 SHALL place the counter widths, the throttle modulus (100), the tuser length field bounds and the state encoding in the shared package axis_pkt_checker_pkg.
REQ-027 SHALL instantiate one sub-module, axis_keep_decode: combinational tkeep to popcount plus a contiguity flag, parameterised by tkeep width.

Verification
REQ-028 SHALL cover single-beat packets, with THROTTLE_PERCENT=0: a 60-byte packet (tkeep=2^60-1, tuser=60, tlast=1) is accepted → pkt_count=1, byte_count=60, both error counts 0, and busy never asserts.
REQ-029 SHALL cover multi-beat packets: a 3-beat, 150-byte packet (64+64+22 bytes) with tuser=150 → byte_count=150 and busy high from the cycle after beat 1 until the cycle after beat 3; a second such packet with tuser=151 → len_err_count=1 and err_flag=1.
REQ-030 SHALL cover keep errors: a non-last beat with tkeep=0xFFFF_FFFF_FFFF_FFFE, plus a last beat with tkeep=0x5 in a separate packet → keep_err_count=2.
REQ-031 SHALL cover throttling: with THROTTLE_PERCENT=50 and enable held high for 200 cycles, tready is high for exactly 100 cycles, in two runs of 50; with enable low, tready is 0 and in-packet state is held.
REQ-032 SHALL cover clear and reset: clear coincident with tlast acceptance → all counters 0 and that packet is not counted; reset mid-packet → busy=0, and the next 64-byte single beat counts as pkt_count=1 with no errors.
REQ-033 SHALL cover saturation: 65,537 length-error packets → len_err_count holds at 0xFFFF.
